// File: rtl/apb_periph_bridge.sv
// APB3 slave bridging the system bus onto the accelerator peripheral register/RAM port.
// PREADY is registered; reads complete after a fixed latency or on p_rd_ack with a timeout.
module apb_periph_bridge #(
    parameter int unsigned P_ADDR_W   = 6,
    parameter int unsigned P_DATA_W   = 16,
    parameter int unsigned RO_BASE    = 32,
    parameter logic [31:0] WR_MASK    = 32'h19,
    parameter int unsigned WR_WAIT    = 0,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned RD_LATENCY = 5,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [31:0]         PADDR,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic                PREADY,
    output logic [31:0]         PRDATA,
    output logic                PSLVERR,
    output logic [P_ADDR_W-1:0] p_address,
    output logic [P_DATA_W-1:0] p_data,
    output logic                p_wr,
    output logic                p_rd,
    input  logic                p_rd_ack,
    input  logic [P_DATA_W-1:0] p_data_back,
    output logic                txn_err
);

    localparam int unsigned MaxWrRd = (WR_WAIT > RD_LATENCY) ? WR_WAIT : RD_LATENCY;
    localparam int unsigned MaxCnt  = (MaxWrRd > RD_TIMEOUT) ? MaxWrRd : RD_TIMEOUT;
    localparam int unsigned CntW    = (MaxCnt > 0) ? $clog2(MaxCnt + 1) : 1;

    localparam logic [CntW-1:0] WrWaitInit = CntW'(WR_WAIT);
    localparam logic [CntW-1:0] RdLatLast  = CntW'(RD_LATENCY - 1);
    localparam logic [CntW-1:0] RdToLast   = CntW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWrWait,
        StRdWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [31:0]         prdata_q, prdata_d;
    logic [P_ADDR_W-1:0] p_address_q, p_address_d;
    logic [P_DATA_W-1:0] p_data_q, p_data_d;
    logic                p_wr_q, p_wr_d;
    logic                p_rd_q, p_rd_d;

    logic                setup;
    logic                out_of_range;
    logic                writable;
    logic [P_ADDR_W-1:0] addr;
    logic [P_DATA_W-1:0] wdata;
    logic [31:0]         addr_off;
    logic [31:0]         rd_ext;
    logic [CntW-1:0]     cnt_dec;
    logic                unused_pwdata;

    assign unused_pwdata = ^(PWDATA >> P_DATA_W);

    always_comb begin
        setup        = PSEL & ~PENABLE;
        addr         = PADDR[P_ADDR_W-1:0];
        wdata        = PWDATA[P_DATA_W-1:0];
        out_of_range = (PADDR >> P_ADDR_W) != 32'd0;
        addr_off     = 32'(addr) - RO_BASE;
        // Register-region offsets past the 32-bit mask are treated as read-only.
        writable     = (32'(addr) < RO_BASE) ||
                       ((addr_off < 32'd32) && WR_MASK[addr_off[4:0]]);
        rd_ext                = '0;
        rd_ext[P_DATA_W-1:0]  = p_data_back;
        cnt_dec      = cnt_q - 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = prdata_q;
        p_address_d = p_address_q;
        p_data_d    = p_data_q;
        p_wr_d      = 1'b0;
        p_rd_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    if (out_of_range) begin
                        state_d   = StResp;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        if (!PWRITE) begin
                            prdata_d = '0;
                        end
                    end else if (PWRITE) begin
                        if (writable) begin
                            p_address_d = addr;
                            p_data_d    = wdata;
                            p_wr_d      = 1'b1;
                            if (WR_WAIT == 0) begin
                                state_d  = StResp;
                                pready_d = 1'b1;
                            end else begin
                                state_d = StWrWait;
                                cnt_d   = WrWaitInit;
                            end
                        end else begin
                            state_d   = StResp;
                            pready_d  = 1'b1;
                            pslverr_d = 1'b1;
                        end
                    end else begin
                        p_address_d = addr;
                        p_rd_d      = 1'b1;
                        cnt_d       = '0;
                        state_d     = StRdWait;
                    end
                end
            end

            StWrWait: begin
                // Master dropped PSEL: abandon quietly, the p_wr already went out.
                if (!PSEL) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        pready_d = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end

            StRdWait: begin
                if (!PSEL) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (RD_MODE == 0) begin
                    if (cnt_q == RdLatLast) begin
                        prdata_d = rd_ext;
                        pready_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Ack takes priority over a timeout on the same edge.
                    if (p_rd_ack) begin
                        prdata_d = rd_ext;
                        pready_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIdle;
                    end else if (cnt_q == RdToLast) begin
                        prdata_d  = '0;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            p_address_q <= '0;
            p_data_q    <= '0;
            p_wr_q      <= 1'b0;
            p_rd_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
            p_address_q <= p_address_d;
            p_data_q    <= p_data_d;
            p_wr_q      <= p_wr_d;
            p_rd_q      <= p_rd_d;
        end
    end

    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign txn_err   = pslverr_q;
    assign PRDATA    = prdata_q;
    assign p_address = p_address_q;
    assign p_data    = p_data_q;
    assign p_wr      = p_wr_q;
    assign p_rd      = p_rd_q;

endmodule

// File: tb/tb_apb_periph_bridge.sv
// Scoreboard bench for apb_periph_bridge: a default instance (fixed-latency reads) and
// an instance with write wait states and acknowledged reads, sharing the APB bus.
`timescale 1ns/1ps
module tb_apb_periph_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR, PWDATA;
    logic        PENABLE, PWRITE;
    logic        psel0, psel1;

    logic        pready0, pslverr0, p_wr0, p_rd0, txn_err0, p_rd_ack0;
    logic [31:0] prdata0;
    logic [5:0]  p_address0;
    logic [15:0] p_data0, p_data_back0;

    logic        pready1, pslverr1, p_wr1, p_rd1, txn_err1, p_rd_ack1;
    logic [31:0] prdata1;
    logic [5:0]  p_address1;
    logic [15:0] p_data1, p_data_back1;

    typedef struct {
        int          lat;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          ready;
        int          lat;
        bit          err;
        bit          terr;
        logic [31:0] rdata;
    } obs_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          wr_cnt0 = 0, rd_cnt0 = 0, rdy_cnt0 = 0, wr_cnt1 = 0, rd_cnt1 = 0, rdy_cnt1 = 0;
    int          stray = 0;
    logic [5:0]  last_addr0, last_addr1, last_rd_addr0;
    logic [15:0] last_data0, last_data1;

    always #5 PCLK = ~PCLK;

    apb_periph_bridge u_dut0 (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PADDR       (PADDR),
        .PSEL        (psel0),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PREADY      (pready0),
        .PRDATA      (prdata0),
        .PSLVERR     (pslverr0),
        .p_address   (p_address0),
        .p_data      (p_data0),
        .p_wr        (p_wr0),
        .p_rd        (p_rd0),
        .p_rd_ack    (p_rd_ack0),
        .p_data_back (p_data_back0),
        .txn_err     (txn_err0)
    );

    apb_periph_bridge #(
        .WR_WAIT    (2),
        .RD_MODE    (1),
        .RD_TIMEOUT (8)
    ) u_dut1 (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PADDR       (PADDR),
        .PSEL        (psel1),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PREADY      (pready1),
        .PRDATA      (prdata1),
        .PSLVERR     (pslverr1),
        .p_address   (p_address1),
        .p_data      (p_data1),
        .p_wr        (p_wr1),
        .p_rd        (p_rd1),
        .p_rd_ack    (p_rd_ack1),
        .p_data_back (p_data_back1),
        .txn_err     (txn_err1)
    );

    // Mid-cycle monitor: strobe counts, captured strobe payloads, error-without-ready events.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1) begin
            if (p_wr0) begin wr_cnt0++; last_addr0 = p_address0; last_data0 = p_data0; end
            if (p_wr1) begin wr_cnt1++; last_addr1 = p_address1; last_data1 = p_data1; end
            if (p_rd0) begin rd_cnt0++; last_rd_addr0 = p_address0; end
            if (p_rd1) rd_cnt1++;
            if (pready0) rdy_cnt0++;
            if (pready1) rdy_cnt1++;
            if (!pready0 && (pslverr0 || txn_err0)) stray++;
            if (!pready1 && (pslverr1 || txn_err1)) stray++;
            if (txn_err0 !== pslverr0 || txn_err1 !== pslverr1) stray++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // One APB transfer on instance d; latency counts access cycles up to PREADY (first = 1).
    task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int max_cyc, output obs_t o);
        o.ready = 1'b0; o.lat = 0; o.err = 1'b0; o.terr = 1'b0; o.rdata = '0;
        PADDR = addr; PWRITE = wr; PWDATA = wd; PENABLE = 1'b0;
        if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            if ((d == 0) ? pready0 : pready1) begin
                o.ready = 1'b1;
                o.lat   = i;
                o.err   = (d == 0) ? pslverr0 : pslverr1;
                o.terr  = (d == 0) ? txn_err0 : txn_err1;
                o.rdata = (d == 0) ? prdata0 : prdata1;
                break;
            end
            @(posedge PCLK); #1;
        end
        if (o.ready) begin @(posedge PCLK); #1; end
        psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if ({pready0, prdata0, pslverr0, p_address0, p_data0, p_wr0, p_rd0, txn_err0} !== '0) begin
            errors++; $display("FAIL reset_dut0: got nonzero outputs required all zero");
        end
        checks++;
        if ({pready1, prdata1, pslverr1, p_address1, p_data1, p_wr1, p_rd1, txn_err1} !== '0) begin
            errors++; $display("FAIL reset_dut1: got nonzero outputs required all zero");
        end
        @(negedge PCLK); PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if ({pready0, pslverr0, p_wr0, p_rd0, pready1, pslverr1, p_wr1, p_rd1} !== '0) begin
            errors++; $display("FAIL post_reset_idle: strobes active with no transfer, required 0");
        end
    endtask

    task automatic test_write();
        obs_t o; exp_t e; int wr_b;
        wr_b = wr_cnt0;
        exp_q.push_back('{lat: 1, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
        apb_xfer(0, 1'b1, 32'h05, 32'hCAFE_BEEF, 20, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err || o.terr != e.err) begin
            errors++; $display("FAIL write_resp: got lat=%0d err=%0b terr=%0b required lat=%0d err=%0b",
                               o.lat, o.err, o.terr, e.lat, e.err);
        end
        checks++;
        if (wr_cnt0 - wr_b != 1) begin
            errors++; $display("FAIL write_strobe: got %0d p_wr cycles required 1", wr_cnt0 - wr_b);
        end
        checks++;
        if (last_addr0 !== 6'h05 || last_data0 !== 16'hBEEF) begin
            errors++; $display("FAIL write_payload: got addr=%h data=%h required addr=05 data=beef",
                               last_addr0, last_data0);
        end
    endtask

    task automatic test_ro_write();
        obs_t o; exp_t e; int wr_b;
        logic [31:0] addrs [3] = '{32'h21, 32'h23, 32'h24};
        bit          errs  [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            wr_b = wr_cnt0;
            exp_q.push_back('{lat: 1, err: errs[i], chk_rd: 1'b0, rdata: 32'h0});
            apb_xfer(0, 1'b1, addrs[i], 32'h1000 + i, 20, o);
            e = exp_q.pop_front();
            checks++;
            if (o.lat != e.lat || o.err != e.err || o.terr != e.err) begin
                errors++; $display("FAIL map_write_%h: got lat=%0d err=%0b terr=%0b required lat=%0d err=%0b",
                                   addrs[i], o.lat, o.err, o.terr, e.lat, e.err);
            end
            checks++;
            if (wr_cnt0 - wr_b != (e.err ? 0 : 1)) begin
                errors++; $display("FAIL map_strobe_%h: got %0d p_wr required %0d",
                                   addrs[i], wr_cnt0 - wr_b, e.err ? 0 : 1);
            end
        end
    endtask

    task automatic test_wr_wait();
        obs_t o; exp_t e; int wr_b, rdy_b;
        wr_b = wr_cnt1; rdy_b = rdy_cnt1;
        p_rd_ack1 = 1'b1;  // stray ack outside a read must not complete anything
        repeat (2) @(posedge PCLK);
        #1;
        exp_q.push_back('{lat: 3, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
        apb_xfer(1, 1'b1, 32'h00, 32'h7777, 20, o);
        p_rd_ack1 = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err) begin
            errors++; $display("FAIL wr_wait: got lat=%0d err=%0b required lat=%0d err=%0b",
                               o.lat, o.err, e.lat, e.err);
        end
        checks++;
        if (wr_cnt1 - wr_b != 1 || last_data1 !== 16'h7777 || rdy_cnt1 - rdy_b != 1) begin
            errors++; $display("FAIL wr_wait_strobe: got p_wr=%0d data=%h ready=%0d required 1 7777 1",
                               wr_cnt1 - wr_b, last_data1, rdy_cnt1 - rdy_b);
        end
    endtask

    task automatic test_rd_fixed();
        obs_t o; exp_t e; int rd_b;
        rd_b = rd_cnt0;
        p_data_back0 = 16'h1234;
        p_rd_ack0 = 1'b1;  // ignored in fixed-latency mode
        exp_q.push_back('{lat: 6, err: 1'b0, chk_rd: 1'b1, rdata: 32'h0000_1234});
        apb_xfer(0, 1'b0, 32'h22, 32'h0, 20, o);
        p_rd_ack0 = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err || o.rdata !== e.rdata) begin
            errors++; $display("FAIL rd_fixed: got lat=%0d err=%0b data=%h required lat=%0d err=%0b data=%h",
                               o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
        end
        checks++;
        if (rd_cnt0 - rd_b != 1 || last_rd_addr0 !== 6'h22) begin
            errors++; $display("FAIL rd_strobe: got p_rd=%0d addr=%h required 1 22",
                               rd_cnt0 - rd_b, last_rd_addr0);
        end
    endtask

    task automatic test_rd_ack();
        obs_t o; exp_t e;
        p_data_back1 = 16'h0;
        exp_q.push_back('{lat: 4, err: 1'b0, chk_rd: 1'b1, rdata: 32'h0000_A5A5});
        fork
            apb_xfer(1, 1'b0, 32'h22, 32'h0, 20, o);
            begin
                repeat (3) begin @(posedge PCLK); #1; end
                p_rd_ack1 = 1'b1; p_data_back1 = 16'hA5A5;
                @(posedge PCLK); #1;
                p_rd_ack1 = 1'b0; p_data_back1 = 16'h5A5A;
            end
        join
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err || o.rdata !== e.rdata) begin
            errors++; $display("FAIL rd_ack: got lat=%0d err=%0b data=%h required lat=%0d err=%0b data=%h",
                               o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
        end
    endtask

    task automatic test_rd_timeout();
        obs_t o; exp_t e;
        exp_q.push_back('{lat: 9, err: 1'b1, chk_rd: 1'b1, rdata: 32'h0});
        apb_xfer(1, 1'b0, 32'h22, 32'h0, 20, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err || o.terr != e.err || o.rdata !== e.rdata) begin
            errors++; $display("FAIL rd_timeout: got lat=%0d err=%0b terr=%0b data=%h required lat=%0d err=1 data=%h",
                               o.lat, o.err, o.terr, o.rdata, e.lat, e.rdata);
        end
    endtask

    task automatic test_out_of_range();
        obs_t o; exp_t e; int rd_b, wr_b;
        rd_b = rd_cnt0; wr_b = wr_cnt0;
        exp_q.push_back('{lat: 1, err: 1'b1, chk_rd: 1'b1, rdata: 32'h0});
        apb_xfer(0, 1'b0, 32'h100, 32'h0, 20, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err || o.terr != e.err || o.rdata !== e.rdata) begin
            errors++; $display("FAIL oor_read: got lat=%0d err=%0b terr=%0b data=%h required lat=1 err=1 data=0",
                               o.lat, o.err, o.terr, o.rdata);
        end
        exp_q.push_back('{lat: 1, err: 1'b1, chk_rd: 1'b0, rdata: 32'h0});
        apb_xfer(0, 1'b1, 32'h40, 32'h55, 20, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err) begin
            errors++; $display("FAIL oor_write: got lat=%0d err=%0b required lat=1 err=1", o.lat, o.err);
        end
        checks++;
        if (rd_cnt0 != rd_b || wr_cnt0 != wr_b) begin
            errors++; $display("FAIL oor_strobes: got p_rd=%0d p_wr=%0d required 0 0",
                               rd_cnt0 - rd_b, wr_cnt0 - wr_b);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2, o3; exp_t e; time t0, t1;
        p_data_back0 = 16'h00FF;
        exp_q.push_back('{lat: 1, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
        exp_q.push_back('{lat: 6, err: 1'b0, chk_rd: 1'b1, rdata: 32'h0000_00FF});
        t0 = $time;
        apb_xfer(0, 1'b1, 32'h03, 32'h1111, 20, o1);
        apb_xfer(0, 1'b0, 32'h10, 32'h0, 20, o2);
        t1 = $time;
        e = exp_q.pop_front();
        checks++;
        if (o1.lat != e.lat || o1.err != e.err) begin
            errors++; $display("FAIL b2b_write: got lat=%0d err=%0b required lat=1 err=0", o1.lat, o1.err);
        end
        e = exp_q.pop_front();
        checks++;
        if (o2.lat != e.lat || o2.err != e.err || o2.rdata !== e.rdata) begin
            errors++; $display("FAIL b2b_read: got lat=%0d err=%0b data=%h required lat=6 err=0 data=%h",
                               o2.lat, o2.err, o2.rdata, e.rdata);
        end
        checks++;
        if (t1 - t0 != 90) begin
            errors++; $display("FAIL b2b_duration: got %0t ns required 90 ns", t1 - t0);
        end
        apb_xfer(0, 1'b1, 32'h04, 32'h2222, 20, o3);
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if (prdata0 !== 32'h0000_00FF) begin
            errors++; $display("FAIL prdata_hold: got %h required 000000ff", prdata0);
        end
    endtask

    task automatic test_abort();
        obs_t o; int rdy_b;
        rdy_b = rdy_cnt0;
        PADDR = 32'h22; PWRITE = 1'b0; PENABLE = 1'b0; psel0 = 1'b1;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1; psel0 = 1'b0; PENABLE = 1'b0;
        repeat (10) @(posedge PCLK);
        #1;
        checks++;
        if (rdy_cnt0 != rdy_b) begin
            errors++; $display("FAIL abort_ready: got %0d PREADY pulses required 0", rdy_cnt0 - rdy_b);
        end
        apb_xfer(0, 1'b1, 32'h05, 32'h3333, 20, o);
        checks++;
        if (o.lat != 1 || o.err != 1'b0) begin
            errors++; $display("FAIL abort_recover: got lat=%0d err=%0b required lat=1 err=0", o.lat, o.err);
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL err_without_ready: got %0d events required 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e; logic rd_seen;
        PADDR = 32'h22; PWRITE = 1'b0; PENABLE = 1'b0; psel1 = 1'b1;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        rd_seen = p_rd1;
        #2; PRESETn = 1'b0;
        #1;
        checks++;
        if (rd_seen !== 1'b1) begin
            errors++; $display("FAIL mid_reset_setup: got p_rd=%b required 1", rd_seen);
        end
        checks++;
        if ({pready1, prdata1, pslverr1, p_address1, p_data1, p_wr1, p_rd1, txn_err1} !== '0) begin
            errors++; $display("FAIL mid_reset_async: got nonzero outputs required all zero");
        end
        psel1 = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        @(posedge PCLK); #1;
        exp_q.push_back('{lat: 3, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
        apb_xfer(1, 1'b1, 32'h00, 32'h4444, 20, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat != e.lat || o.err != e.err) begin
            errors++; $display("FAIL mid_reset_recover: got lat=%0d err=%0b required lat=%0d err=0",
                               o.lat, o.err, e.lat);
        end
    endtask

    initial begin
        PRESETn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; p_rd_ack0 = 1'b0; p_rd_ack1 = 1'b0;
        p_data_back0 = 16'hDEAD; p_data_back1 = 16'hDEAD;
        test_reset();
        test_write();
        test_ro_write();
        test_wr_wait();
        test_rd_fixed();
        test_rd_ack();
        test_rd_timeout();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
